// File: rtl/instruction_encoder_if.sv
// ============================================================================
// Module   : instruction_encoder_if
// Purpose  : Field-set handshake and instruction-memory write port bundle
//            between a field producer and instruction_encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_encoder_if #(
  parameter int INSTRUCTION_WIDTH      = 16,
  parameter int ID_WIDTH               = 7,
  parameter int REGISTER_WIDTH         = 4,
  parameter int OFFSET_WIDTH           = 12,
  parameter int BRANCH_CONDITION_WIDTH = 5,
  parameter int ADDR_WIDTH             = 12
);
  logic                              in_valid;
  logic                              in_ready;
  logic [ID_WIDTH-1:0]               ID;
  logic [REGISTER_WIDTH-1:0]         RegD;
  logic [REGISTER_WIDTH-1:0]         RegA;
  logic [REGISTER_WIDTH-1:0]         RegB;
  logic [OFFSET_WIDTH-1:0]           Offset;
  logic [BRANCH_CONDITION_WIDTH-1:0] branch_condition;
  logic                              mem_grant;
  logic                              mem_wren;
  logic [ADDR_WIDTH-1:0]             mem_address;
  logic [INSTRUCTION_WIDTH-1:0]      mem_data;

  modport master (
    output in_valid, ID, RegD, RegA, RegB, Offset, branch_condition, mem_grant,
    input  in_ready, mem_wren, mem_address, mem_data
  );

  modport slave (
    input  in_valid, ID, RegD, RegA, RegB, Offset, branch_condition, mem_grant,
    output in_ready, mem_wren, mem_address, mem_data
  );
endinterface

`default_nettype wire

// File: rtl/instruction_encoder.sv
// ============================================================================
// Module   : instruction_encoder
// Purpose  : Re-encodes decoded ARMAria instruction fields into 16-bit words
//            and streams them to instruction memory through a small FIFO.
//            Optional macro ENCODER_SYSTEM_OPS_EN enables the opcode-1011 group.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_encoder #(
  parameter int INSTRUCTION_WIDTH      = 16,
  parameter int ID_WIDTH               = 7,
  parameter int REGISTER_WIDTH         = 4,
  parameter int OFFSET_WIDTH           = 12,
  parameter int BRANCH_CONDITION_WIDTH = 5,
  parameter int ADDR_WIDTH             = 12,
  parameter int FIFO_DEPTH             = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_address,
  instruction_encoder_if.slave          bus,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          error,
  output logic [ID_WIDTH-1:0]           error_id,
  output logic [15:0]                   words_written
);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;

  logic [INSTRUCTION_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_LVL_W-1:0]           level_q, level_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic                         error_q, error_d;
  logic [ID_WIDTH-1:0]          error_id_q, error_id_d;
  logic [15:0]                  words_q, words_d;

  logic [INSTRUCTION_WIDTH-1:0] w_word;
  logic                         w_ok, w_accept, w_push, w_pop;
  logic [ID_WIDTH-1:0]          w_rel;
  logic [4:0]                   w_gf;
  logic [3:0]                   w_opc;
  logic [2:0]                   w_rd, w_ra, w_rb;
  logic [7:0]                   w_off;
  logic [3:0]                   w_cond;
  logic                         w_unused;

  assign w_rd   = bus.RegD[2:0];
  assign w_ra   = bus.RegA[2:0];
  assign w_rb   = bus.RegB[2:0];
  assign w_off  = bus.Offset[7:0];
  assign w_cond = bus.branch_condition[3:0];
  // Field bits above their encoded slot width are dropped by design.
  assign w_unused = ^{bus.RegD, bus.RegA, bus.RegB, bus.Offset, bus.branch_condition, w_rel};

  always_comb begin
    w_word = '0;
    w_ok   = 1'b1;
    w_rel  = '0;
    w_gf   = '0;
    w_opc  = '0;
    case (bus.ID) inside
      7'd1, 7'd2:    w_word = {4'b0000, ~bus.ID[0], w_off[4:0], w_ra, w_rd};
      7'd3:          w_word = {4'b0001, 1'b0, w_off[4:0], w_ra, w_rd};
      [7'd4:7'd7]: begin
        w_rel  = bus.ID - 7'd4;
        w_word = {4'b0001, 1'b1, w_rel[1:0], (bus.ID[1] ? w_off[2:0] : w_rb), w_ra, w_rd};
      end
      [7'd8:7'd11]:  w_word = {3'b001, bus.ID[1], bus.ID[0], w_rd, w_off};
      [7'd12:7'd27]: begin
        w_rel  = bus.ID - 7'd12;
        w_word = {4'b0100, 1'b0, w_rel[4:0], w_rb, w_rd};
      end
      [7'd28:7'd37]: begin
        // Group/function pairs are irregular here, so they are tabulated.
        case (bus.ID)
          7'd28:   w_gf = {3'd4, 2'd1};
          7'd29:   w_gf = {3'd4, 2'd2};
          7'd30:   w_gf = {3'd4, 2'd3};
          7'd31:   w_gf = {3'd5, 2'd1};
          7'd32:   w_gf = {3'd5, 2'd2};
          7'd33:   w_gf = {3'd5, 2'd3};
          default: begin
            w_rel = bus.ID - 7'd34;
            w_gf  = {3'd6, w_rel[1:0]};
          end
        endcase
        w_word = {4'b0100, 1'b0, w_gf, w_rb, w_rd};
      end
      7'd38:         w_word = {4'b0100, 4'b0111, w_cond, 1'b0, w_rb};
      7'd77:         w_word = {4'b0100, 4'b0111, 4'b1111, 1'b0, w_rb};
      7'd39:         w_word = {4'b0100, 1'b1, w_rd, w_off};
      [7'd40:7'd47]: begin
        w_rel  = bus.ID - 7'd40;
        w_word = {4'b0101, w_rel[2:0], w_rb, w_ra, w_rd};
      end
      [7'd48:7'd53]: begin
        w_rel  = bus.ID - 7'd48;
        w_opc  = 4'd6 + {2'b00, w_rel[2:1]};
        w_word = {w_opc, bus.ID[0], w_off[4:0], w_ra, w_rd};
      end
      7'd54, 7'd55:  w_word = {4'b1001, bus.ID[0], w_rd, w_off};
      7'd56, 7'd57:  w_word = {4'b1010, bus.ID[0], w_rd, w_off};
      7'd72:         w_word = {4'b1100, 1'b0, w_off[4:0], 6'b000000};
      7'd73:         w_word = {4'b1101, w_cond, w_off};
      7'd74, 7'd75:  w_word = {4'b1110, bus.ID[0], 11'b0};
      7'd100:        w_word = 16'hFFFF;
`ifdef ENCODER_SYSTEM_OPS_EN
      7'd58:         w_word = {4'b1011, 4'b0000, 2'b00, 3'b000, w_rd};
      7'd76:         w_word = {4'b1011, 4'b0000, 2'b01, 3'b000, w_rd};
      [7'd59:7'd62]: begin
        w_rel  = bus.ID - 7'd59;
        w_word = {4'b1011, 4'b0010, w_rel[1:0], w_rb, w_rd};
      end
      [7'd63:7'd66]: begin
        w_rel  = bus.ID - 7'd63;
        w_word = {4'b1011, 4'b1010, w_rel[1:0], w_rb, w_rd};
      end
      7'd67:         w_word = {4'b1011, 4'b0100, 5'b00000, w_rd};
      7'd68:         w_word = {4'b1011, 4'b1101, 5'b00000, w_rd};
      7'd69:         w_word = {4'b1011, 4'b1110, 2'd0, 3'b000, w_rd};
      7'd70:         w_word = {4'b1011, 4'b1110, 2'd1, 3'b000, 3'b000};
      7'd71:         w_word = {4'b1011, 4'b1110, 2'd2, 3'b000, w_rd};
`endif
      default:       w_ok = 1'b0;
    endcase
  end

  assign bus.in_ready    = (level_q < c_LVL_W'(FIFO_DEPTH));
  assign w_accept        = bus.in_valid & bus.in_ready;
  assign w_push          = w_accept & w_ok;
  assign w_pop           = bus.mem_grant & (level_q != '0);
  assign bus.mem_wren    = w_pop;
  assign bus.mem_address = addr_q;
  assign bus.mem_data    = (level_q != '0) ? fifo_q[rd_ptr_q] : '0;
  assign level           = level_q;
  assign error           = error_q;
  assign error_id        = error_id_q;
  assign words_written   = words_q;

  always_comb begin
    wr_ptr_d   = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q;
    addr_d     = addr_q;
    error_d    = error_q;
    error_id_d = error_id_q;
    words_d    = w_pop ? words_q + 16'd1 : words_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // start overrides the post-write increment; the write itself used addr_q.
    if (start) begin
      addr_d     = base_address;
      error_d    = 1'b0;
      error_id_d = '0;
    end else begin
      if (w_pop) addr_d = addr_q + 1'b1;
      if (w_accept && !w_ok) begin
        error_d = 1'b1;
        if (!error_q) error_id_d = bus.ID;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      addr_q     <= '0;
      error_q    <= 1'b0;
      error_id_q <= '0;
      words_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      addr_q     <= addr_d;
      error_q    <= error_d;
      error_id_q <= error_id_d;
      words_q    <= words_d;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) fifo_q[wr_ptr_q] <= w_word;
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_encoder.sv
// ============================================================================
// Module   : tb_instruction_encoder
// Purpose  : Directed self-checking bench for instruction_encoder with a
//            scoreboard of expected memory writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_encoder;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] base_address;
  logic [2:0]  level;
  logic        error;
  logic [6:0]  error_id;
  logic [15:0] words_written;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [11:0] exp_addr = '0;

  instruction_encoder_if bus ();

  instruction_encoder dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .base_address  (base_address),
    .bus           (bus),
    .level         (level),
    .error         (error),
    .error_id      (error_id),
    .words_written (words_written)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobed write must match the oldest expected word.
  always @(negedge clock) begin
    if (reset === 1'b1 && bus.mem_wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("write_without_expected", 32'(bus.mem_wren), 32'd0);
      end else begin
        check("mem_address", 32'(bus.mem_address), 32'(exp_addr));
        check("mem_data", 32'(bus.mem_data), 32'(exp_q.pop_front()));
        exp_addr = exp_addr + 12'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [11:0] base);
    base_address = base;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    exp_addr     = base;
  endtask

  task automatic send(input logic [6:0] id, input logic [3:0] rd, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [11:0] off, input logic [4:0] cond,
                      input logic [15:0] word, input bit sup);
    bit acc = 1'b0;
    bus.ID = id; bus.RegD = rd; bus.RegA = ra; bus.RegB = rb;
    bus.Offset = off; bus.branch_condition = cond;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (bus.in_ready === 1'b1) begin
        acc = 1'b1;
        break;
      end
    end
    tick();
    bus.in_valid = 1'b0;
    check("handshake_accepted", 32'(acc), 32'd1);
    if (acc && sup) exp_q.push_back(word);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (level != 3'd0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    tick();
    check("drain_in_time", 32'(n < 100), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; base_address = '0;
    bus.in_valid = 1'b0; bus.mem_grant = 1'b0; bus.ID = '0;
    bus.RegD = '0; bus.RegA = '0; bus.RegB = '0; bus.Offset = '0; bus.branch_condition = '0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mem_wren", 32'(bus.mem_wren), 32'd0);
    check("rst_mem_address", 32'(bus.mem_address), 32'd0);
    check("rst_mem_data", 32'(bus.mem_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_error_id", 32'(error_id), 32'd0);
    check("rst_words_written", 32'(words_written), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Single word, minimum latency
    do_start(12'h010);
    check("start_address", 32'(bus.mem_address), 32'h010);
    bus.mem_grant = 1'b1;
    send(7'h08, 4'd3, 4'd0, 4'd0, 12'h05A, 5'd0, 16'h235A, 1'b1);
    check("level_after_push", 32'(level), 32'd1);
    wait_empty();
    check("words_after_first", 32'(words_written), 32'd1);

    // Back-to-back stream with continuous grant
    send(7'h2A, 4'd1, 4'd2, 4'd3, 12'h000, 5'd0, 16'h54D1, 1'b1);
    send(7'h49, 4'd0, 4'd0, 4'd0, 12'h0FE, 5'd0, 16'hD0FE, 1'b1);
    send(7'h64, 4'd0, 4'd0, 4'd0, 12'h000, 5'd0, 16'hFFFF, 1'b1);
    wait_empty();
    check("words_after_stream", 32'(words_written), 32'd4);
    check("address_after_stream", 32'(bus.mem_address), 32'h014);

    // Fill the FIFO with grant low, then drain
    bus.mem_grant = 1'b0;
    send(7'd1,  4'd5, 4'd6, 4'd0, 12'h013, 5'd0,  16'h04F5, 1'b1);
    send(7'd30, 4'd7, 4'd0, 4'd2, 12'h000, 5'd0,  16'h44D7, 1'b1);
    send(7'd77, 4'd0, 4'd0, 4'd5, 12'h000, 5'd3,  16'h47F5, 1'b1);
    send(7'd55, 4'd2, 4'd0, 4'd0, 12'h03C, 5'd0,  16'h9A3C, 1'b1);
    check("full_level", 32'(level), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.ID = 7'd5; bus.RegD = 4'd6; bus.RegA = 4'd1; bus.RegB = 4'd4;
    bus.Offset = '0; bus.branch_condition = '0;
    bus.in_valid = 1'b1;
    bus.mem_grant = 1'b1;
    @(negedge clock);
    check("full_pop_no_ready", 32'(bus.in_ready), 32'd0);
    check("full_wren", 32'(bus.mem_wren), 32'd1);
    tick();
    check("after_pop_level", 32'(level), 32'd3);
    check("after_pop_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("push_pop_level", 32'(level), 32'd3);
    bus.in_valid = 1'b0;
    exp_q.push_back(16'h1B0E);
    wait_empty();
    check("words_after_fill", 32'(words_written), 32'd9);

    // Unsupported IDs
    send(7'h7F, 4'd0, 4'd0, 4'd0, 12'h000, 5'd0, 16'h0000, 1'b0);
    send(7'h7E, 4'd0, 4'd0, 4'd0, 12'h000, 5'd0, 16'h0000, 1'b0);
    tick();
    check("bad_level", 32'(level), 32'd0);
    check("bad_error", 32'(error), 32'd1);
    check("bad_error_id", 32'(error_id), 32'h7F);
    check("bad_words", 32'(words_written), 32'd9);
    do_start(12'h020);
    check("start_clears_error", 32'(error), 32'd0);
    check("start_clears_error_id", 32'(error_id), 32'd0);

    // Optional system-op group
`ifdef ENCODER_SYSTEM_OPS_EN
    send(7'h45, 4'd5, 4'd0, 4'd0, 12'h000, 5'd0, 16'hBE05, 1'b1);
    wait_empty();
    check("sysop_words", 32'(words_written), 32'd10);
    check("sysop_error", 32'(error), 32'd0);
`else
    send(7'h45, 4'd5, 4'd0, 4'd0, 12'h000, 5'd0, 16'h0000, 1'b0);
    tick();
    check("sysop_error", 32'(error), 32'd1);
    check("sysop_error_id", 32'(error_id), 32'h45);
    check("sysop_level", 32'(level), 32'd0);
`endif

    // Address wrap
    do_start(12'hFFF);
    send(7'd72, 4'd0, 4'd0, 4'd0, 12'h015, 5'd0, 16'hC540, 1'b1);
    send(7'd2,  4'd1, 4'd1, 4'd0, 12'h000, 5'd0, 16'h0809, 1'b1);
    wait_empty();
    check("wrap_address", 32'(bus.mem_address), 32'h001);

    // Reset mid-drain
    bus.mem_grant = 1'b0;
    send(7'd39, 4'd4, 4'd0, 4'd0, 12'h081, 5'd0, 16'h4C81, 1'b1);
    send(7'd74, 4'd0, 4'd0, 4'd0, 12'h000, 5'd0, 16'hE000, 1'b1);
    send(7'd75, 4'd0, 4'd0, 4'd0, 12'h000, 5'd0, 16'hE800, 1'b1);
    check("pre_reset_level", 32'(level), 32'd3);
    bus.mem_grant = 1'b1;
    tick();
    check("mid_drain_level", 32'(level), 32'd2);
    reset = 1'b0;
    #1;
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_wren", 32'(bus.mem_wren), 32'd0);
    check("async_rst_address", 32'(bus.mem_address), 32'd0);
    check("async_rst_words", 32'(words_written), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    bus.mem_grant = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("post_reset_data", 32'(bus.mem_data), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
